// File: rtl/mesh_io_skew.sv
// I/O staging ring for the systolic mesh: per-lane boundary registers with optional
// triangular input skew and matching output deskew, plus busy/flush/alignment tracking.
module mesh_io_skew #(
  parameter int ROWS    = 8,
  parameter int A_W     = 8,
  parameter int C_W     = 19,
  parameter int SHIFT_W = 5,
  parameter int SKEW_EN = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     flush,
  input  logic [ROWS*A_W-1:0]      in_a,
  input  logic [ROWS*A_W-1:0]      in_b,
  input  logic [ROWS*A_W-1:0]      in_d,
  input  logic [ROWS-1:0]          in_propagate,
  input  logic [ROWS*SHIFT_W-1:0]  in_shift,
  input  logic [ROWS-1:0]          in_valid,
  output logic [ROWS*A_W-1:0]      mesh_a,
  output logic [ROWS*A_W-1:0]      mesh_b,
  output logic [ROWS*A_W-1:0]      mesh_d,
  output logic [ROWS-1:0]          mesh_propagate,
  output logic [ROWS*SHIFT_W-1:0]  mesh_shift,
  output logic [ROWS-1:0]          mesh_valid,
  input  logic [ROWS*C_W-1:0]      mesh_out_c,
  input  logic [ROWS*C_W-1:0]      mesh_out_b,
  input  logic [ROWS-1:0]          mesh_out_valid,
  output logic [ROWS*C_W-1:0]      out_c,
  output logic [ROWS*C_W-1:0]      out_b,
  output logic [ROWS-1:0]          out_valid,
  output logic                     out_valid_all,
  output logic                     busy,
  output logic                     align_err
);

  localparam int IN_W  = 3*A_W + 1 + SHIFT_W;
  localparam int OUT_W = 2*C_W;

  logic [ROWS-1:0] in_busy;
  logic [ROWS-1:0] out_busy;
  logic            out_valid_all_reg;
  logic            align_err_reg;
  logic            partial_next;

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_lane
      // Lane gi is skewed by gi on the way in and by ROWS-1-gi on the way out,
      // so every lane sees the same total round-trip delay.
      localparam int DI = 1 + ((SKEW_EN != 0) ? gi : 0);
      localparam int DO = 1 + ((SKEW_EN != 0) ? (ROWS - 1 - gi) : 0);

      logic [IN_W-1:0]  in_data_reg  [DI];
      logic             in_vld_reg   [DI];
      logic [OUT_W-1:0] out_data_reg [DO];
      logic             out_vld_reg  [DO];
      logic [IN_W-1:0]  in_bundle;
      logic [OUT_W-1:0] out_bundle;
      logic             in_lane_busy;
      logic             out_lane_busy;

      assign in_bundle  = {in_a[gi*A_W +: A_W], in_b[gi*A_W +: A_W], in_d[gi*A_W +: A_W],
                           in_propagate[gi], in_shift[gi*SHIFT_W +: SHIFT_W]};
      assign out_bundle = {mesh_out_c[gi*C_W +: C_W], mesh_out_b[gi*C_W +: C_W]};

      // Data always shifts; only the valid bits honour flush.
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          for (int s = 0; s < DI; s++) begin
            in_data_reg[s] <= '0;
            in_vld_reg[s]  <= 1'b0;
          end
        end else begin
          in_data_reg[0] <= in_bundle;
          in_vld_reg[0]  <= in_valid[gi] & ~flush;
          for (int s = 1; s < DI; s++) begin
            in_data_reg[s] <= in_data_reg[s-1];
            in_vld_reg[s]  <= in_vld_reg[s-1] & ~flush;
          end
        end
      end

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          for (int s = 0; s < DO; s++) begin
            out_data_reg[s] <= '0;
            out_vld_reg[s]  <= 1'b0;
          end
        end else begin
          out_data_reg[0] <= out_bundle;
          out_vld_reg[0]  <= mesh_out_valid[gi] & ~flush;
          for (int s = 1; s < DO; s++) begin
            out_data_reg[s] <= out_data_reg[s-1];
            out_vld_reg[s]  <= out_vld_reg[s-1] & ~flush;
          end
        end
      end

      always_comb begin
        in_lane_busy = 1'b0;
        for (int s = 0; s < DI; s++) in_lane_busy = in_lane_busy | in_vld_reg[s];
      end

      always_comb begin
        out_lane_busy = 1'b0;
        for (int s = 0; s < DO; s++) out_lane_busy = out_lane_busy | out_vld_reg[s];
      end

      assign in_busy[gi]  = in_lane_busy;
      assign out_busy[gi] = out_lane_busy;

      assign {mesh_a[gi*A_W +: A_W], mesh_b[gi*A_W +: A_W], mesh_d[gi*A_W +: A_W],
              mesh_propagate[gi], mesh_shift[gi*SHIFT_W +: SHIFT_W]} = in_data_reg[DI-1];
      assign mesh_valid[gi] = in_vld_reg[DI-1];

      assign {out_c[gi*C_W +: C_W], out_b[gi*C_W +: C_W]} = out_data_reg[DO-1];
      assign out_valid[gi] = out_vld_reg[DO-1];
    end
  endgenerate

  // A lane arriving without its siblings means the mesh skew did not match ours.
  assign partial_next = (|out_valid) & ~(&out_valid);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_valid_all_reg <= 1'b0;
      align_err_reg     <= 1'b0;
    end else if (flush) begin
      out_valid_all_reg <= 1'b0;
      align_err_reg     <= 1'b0;
    end else begin
      out_valid_all_reg <= &out_valid;
      align_err_reg     <= align_err_reg | partial_next;
    end
  end

  assign out_valid_all = out_valid_all_reg;
  assign align_err     = align_err_reg;
  assign busy          = (|in_busy) | (|out_busy);

endmodule

// File: tb/tb_mesh_io_skew.sv
// Scoreboard bench: a skewed and a flat instance share stimulus; expected beats are queued
// per lane with their due cycle and a negedge monitor pops and compares them.
module tb_mesh_io_skew;
  localparam int ROWS = 8, A_W = 8, C_W = 19, SHIFT_W = 5;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic flush = 1'b0;
  logic [ROWS*A_W-1:0]     in_a = '0, in_b = '0, in_d = '0;
  logic [ROWS-1:0]         in_propagate = '0, in_valid = '0, mesh_out_valid = '0;
  logic [ROWS*SHIFT_W-1:0] in_shift = '0;
  logic [ROWS*C_W-1:0]     mesh_out_c = '0, mesh_out_b = '0;

  logic [ROWS*A_W-1:0]     ma_w [2], mb_w [2], md_w [2];
  logic [ROWS-1:0]         mp_w [2], mv_w [2], ov_w [2];
  logic [ROWS*SHIFT_W-1:0] ms_w [2];
  logic [ROWS*C_W-1:0]     oc_w [2], ob_w [2];
  logic                    ova_w [2], busy_w [2], aerr_w [2];

  always #5 CLK = ~CLK;

  mesh_io_skew #(.ROWS(ROWS), .A_W(A_W), .C_W(C_W), .SHIFT_W(SHIFT_W), .SKEW_EN(1)) u_skew (
    .CLK(CLK), .RST(RST), .flush(flush), .in_a(in_a), .in_b(in_b), .in_d(in_d),
    .in_propagate(in_propagate), .in_shift(in_shift), .in_valid(in_valid),
    .mesh_a(ma_w[0]), .mesh_b(mb_w[0]), .mesh_d(md_w[0]), .mesh_propagate(mp_w[0]),
    .mesh_shift(ms_w[0]), .mesh_valid(mv_w[0]), .mesh_out_c(mesh_out_c), .mesh_out_b(mesh_out_b),
    .mesh_out_valid(mesh_out_valid), .out_c(oc_w[0]), .out_b(ob_w[0]), .out_valid(ov_w[0]),
    .out_valid_all(ova_w[0]), .busy(busy_w[0]), .align_err(aerr_w[0]));

  mesh_io_skew #(.ROWS(ROWS), .A_W(A_W), .C_W(C_W), .SHIFT_W(SHIFT_W), .SKEW_EN(0)) u_flat (
    .CLK(CLK), .RST(RST), .flush(flush), .in_a(in_a), .in_b(in_b), .in_d(in_d),
    .in_propagate(in_propagate), .in_shift(in_shift), .in_valid(in_valid),
    .mesh_a(ma_w[1]), .mesh_b(mb_w[1]), .mesh_d(md_w[1]), .mesh_propagate(mp_w[1]),
    .mesh_shift(ms_w[1]), .mesh_valid(mv_w[1]), .mesh_out_c(mesh_out_c), .mesh_out_b(mesh_out_b),
    .mesh_out_valid(mesh_out_valid), .out_c(oc_w[1]), .out_b(ob_w[1]), .out_valid(ov_w[1]),
    .out_valid_all(ova_w[1]), .busy(busy_w[1]), .align_err(aerr_w[1]));

  typedef struct {
    logic [63:0] data;
    int          n;
    int          due;
  } exp_t;

  exp_t qin  [2*ROWS][$];
  exp_t qout [2*ROWS][$];
  int   cyc = 0;
  int   n_pass = 0, n_total = 0;
  logic m_all [2] = '{1'b0, 1'b0};
  logic m_err [2] = '{1'b0, 1'b0};

  always @(posedge CLK) cyc <= cyc + 1;

  // Instance 0 skews lane i by i in and ROWS-1-i out; instance 1 is a plain register ring.
  function automatic int din(int k, int i);
    return 1 + ((k == 0) ? i : 0);
  endfunction
  function automatic int dout(int k, int i);
    return 1 + ((k == 0) ? (ROWS - 1 - i) : 0);
  endfunction

  task automatic chk(input string name, input int k, input int lane,
                     input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s inst=%0d lane=%0d cyc=%0d actual=%h required=%h",
                  name, k, lane, cyc, act, req);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = '0;
    mesh_out_valid = '0;
    flush = 1'b0;
    in_a = {$urandom, $urandom};
    in_b = {$urandom, $urandom};
    in_d = {$urandom, $urandom};
    in_propagate = 8'($urandom);
    in_shift = 40'({$urandom, $urandom});
    for (int i = 0; i < ROWS; i++) begin
      mesh_out_c[i*C_W +: C_W] = C_W'($urandom);
      mesh_out_b[i*C_W +: C_W] = C_W'($urandom);
    end
  endtask

  // Record what the current cycle's inputs must produce, and when.
  task automatic commit();
    $display("txn cyc=%0d rst_n=%b flush=%b in_valid=%h mesh_out_valid=%h",
             cyc, RST, flush, in_valid, mesh_out_valid);
    if (RST && !flush) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < ROWS; i++) begin
          exp_t e;
          if (in_valid[i]) begin
            e.data = 64'({in_a[i*A_W +: A_W], in_b[i*A_W +: A_W], in_d[i*A_W +: A_W],
                          in_propagate[i], in_shift[i*SHIFT_W +: SHIFT_W]});
            e.n = cyc;
            e.due = cyc + din(k, i);
            qin[k*ROWS+i].push_back(e);
          end
          if (mesh_out_valid[i]) begin
            e.data = 64'({mesh_out_c[i*C_W +: C_W], mesh_out_b[i*C_W +: C_W]});
            e.n = cyc;
            e.due = cyc + dout(k, i);
            qout[k*ROWS+i].push_back(e);
          end
        end
      end
    end
  endtask

  task automatic step(input int n);
    for (int j = 0; j < n; j++) begin
      tick();
      idle_inputs();
      commit();
    end
  endtask

  always @(negedge CLK) begin
    if (cyc > 0) begin
      for (int k = 0; k < 2; k++) begin
        if (!RST) begin
          chk("reset_outputs_zero", k, 0,
              64'(|ma_w[k] | |mb_w[k] | |md_w[k] | |mp_w[k] | |ms_w[k] | |mv_w[k] |
                  |oc_w[k] | |ob_w[k] | |ov_w[k] | ova_w[k] | busy_w[k] | aerr_w[k]), 64'd0);
          for (int i = 0; i < ROWS; i++) begin
            qin[k*ROWS+i].delete();
            qout[k*ROWS+i].delete();
          end
          m_all[k] = 1'b0;
          m_err[k] = 1'b0;
        end else begin
          logic eb;
          logic [ROWS-1:0] exp_ov;
          eb = 1'b0;
          exp_ov = '0;
          for (int q = k*ROWS; q < (k+1)*ROWS; q++) begin
            foreach (qin[q][j])  if (qin[q][j].n < cyc && qin[q][j].due >= cyc) eb = 1'b1;
            foreach (qout[q][j]) if (qout[q][j].n < cyc && qout[q][j].due >= cyc) eb = 1'b1;
          end
          chk("busy", k, 0, 64'(busy_w[k]), 64'(eb));
          chk("out_valid_all", k, 0, 64'(ova_w[k]), 64'(m_all[k]));
          chk("align_err", k, 0, 64'(aerr_w[k]), 64'(m_err[k]));
          for (int i = 0; i < ROWS; i++) begin
            int q;
            q = k*ROWS + i;
            if (qin[q].size() > 0 && qin[q][0].due == cyc) begin
              exp_t e;
              e = qin[q].pop_front();
              chk("mesh_valid", k, i, 64'(mv_w[k][i]), 64'd1);
              chk("mesh_bundle", k, i,
                  64'({ma_w[k][i*A_W +: A_W], mb_w[k][i*A_W +: A_W], md_w[k][i*A_W +: A_W],
                       mp_w[k][i], ms_w[k][i*SHIFT_W +: SHIFT_W]}), e.data);
            end else begin
              chk("mesh_valid_idle", k, i, 64'(mv_w[k][i]), 64'd0);
            end
            if (qout[q].size() > 0 && qout[q][0].due == cyc) begin
              exp_t e;
              e = qout[q].pop_front();
              exp_ov[i] = 1'b1;
              chk("out_valid", k, i, 64'(ov_w[k][i]), 64'd1);
              chk("out_bundle", k, i,
                  64'({oc_w[k][i*C_W +: C_W], ob_w[k][i*C_W +: C_W]}), e.data);
            end else begin
              chk("out_valid_idle", k, i, 64'(ov_w[k][i]), 64'd0);
            end
          end
          if (flush) begin
            m_all[k] = 1'b0;
            m_err[k] = 1'b0;
            for (int q = k*ROWS; q < (k+1)*ROWS; q++) begin
              while (qin[q].size() > 0 && qin[q][$].due > cyc)   void'(qin[q].pop_back());
              while (qout[q].size() > 0 && qout[q][$].due > cyc) void'(qout[q].pop_back());
            end
          end else begin
            m_all[k] = &exp_ov;
            m_err[k] = m_err[k] | ((exp_ov != '0) && (exp_ov != '1));
          end
        end
      end
    end
  end

  initial begin
    // Reset held with random traffic toggling.
    for (int j = 0; j < 5; j++) begin
      tick();
      idle_inputs();
      in_valid = 8'($urandom);
      mesh_out_valid = 8'($urandom);
      flush = 1'($urandom);
      commit();
    end
    tick();
    idle_inputs();
    RST = 1'b1;
    commit();
    step(3);

    // Single aligned beat through the input skew.
    tick();
    idle_inputs();
    in_valid = '1;
    for (int i = 0; i < ROWS; i++) in_a[i*A_W +: A_W] = 8'(8'h10 + i);
    in_shift[3*SHIFT_W +: SHIFT_W] = 5'd7;
    commit();
    step(10);

    // Mesh-skewed results come back aligned.
    for (int i = 0; i < ROWS; i++) begin
      tick();
      idle_inputs();
      mesh_out_valid[i] = 1'b1;
      mesh_out_c[i*C_W +: C_W] = 19'(19'h100 + i);
      commit();
    end
    step(10);

    // Unskewed results leave misaligned; sticky until flush.
    tick();
    idle_inputs();
    mesh_out_valid = '1;
    commit();
    step(12);
    tick();
    idle_inputs();
    flush = 1'b1;
    commit();
    step(2);

    // Four beats, then flush one cycle later.
    for (int j = 0; j < 4; j++) begin
      tick();
      idle_inputs();
      in_valid = '1;
      mesh_out_valid = '1;
      commit();
    end
    tick();
    idle_inputs();
    flush = 1'b1;
    in_valid = '1;
    commit();
    step(10);

    // Random traffic with occasional flush and one mid-stream reset.
    for (int j = 0; j < 300; j++) begin
      tick();
      idle_inputs();
      in_valid = 8'($urandom);
      mesh_out_valid = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      flush = ($urandom_range(0, 19) == 0);
      RST = !(j >= 150 && j < 152);
      commit();
    end
    step(12);

    @(negedge CLK);
    #1;
    for (int q = 0; q < 2*ROWS; q++) begin
      chk("drain_in_empty", q / ROWS, q % ROWS, 64'(qin[q].size()), 64'd0);
      chk("drain_out_empty", q / ROWS, q % ROWS, 64'(qout[q].size()), 64'd0);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
